dds_sample_engine: RTL and testbench

Consumer of the sampling-control outputs (DDSEnable, DDSReady, DDSMode). It advances a phase accumulator once per DDSEnable strobe and shapes the accumulated phase into a DAC code (saw, square, triangle or DC). It sits between the sampling controller and the DAC driver, and emits one registered sample plus a one-cycle valid per accepted strobe.

---
 rtl/dds_pkg.sv | 25 ++
 rtl/dds_wave_shaper.sv | 57 +++++
 rtl/dds_sample_engine.sv | 111 +++++++++++
 tb/tb_dds_sample_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared encodings and helpers for the DDS sample engine: wave selects, FSM states,
// mode decoding and the DAC midscale code.
package dds_pkg;

  localparam logic [1:0] WAVE_SAW = 2'd0;
  localparam logic [1:0] WAVE_SQR = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [1:0] WAVE_DC  = 2'd3;

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    IDLE       = 2'd1,
    RUN        = 2'd2
  } state_t;

  // Rate modes 1..4 mean the sampling controller is producing strobes.
  function automatic logic mode_running(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd4);
  endfunction

  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dds_wave_shaper.sv
// Stage-2 register: shapes the accumulated phase into a DAC code and emits a one-cycle
// valid. A flush forces midscale and suppresses the in-flight sample.
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter int unsigned DATA_W = 10
) (
  input  logic              Fg_CLK,
  input  logic              Fg_RESETn,
  input  logic [DATA_W-1:0] i_phase,
  input  logic [1:0]        i_sel,
  input  logic              i_valid,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale(DATA_W));

  logic [DATA_W-1:0] w_tri;
  logic [DATA_W-1:0] w_shaped;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Triangle folds the upper half of the phase back down.
  assign w_tri = {i_phase[DATA_W-2:0], 1'b0};

  always_comb begin
    w_shaped = MIDSCALE;
    unique case (i_sel)
      WAVE_SAW: w_shaped = i_phase;
      WAVE_SQR: w_shaped = i_phase[DATA_W-1] ? '1 : '0;
      WAVE_TRI: w_shaped = i_phase[DATA_W-1] ? ~w_tri : w_tri;
      WAVE_DC:  w_shaped = MIDSCALE;
      default:  w_shaped = MIDSCALE;
    endcase
  end

  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) begin
      r_data  <= MIDSCALE;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_data  <= MIDSCALE;
      r_valid <= 1'b0;
    end else if (i_valid) begin
      r_data  <= w_shaped;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/dds_sample_engine.sv
// DDS sample engine: FSM gated by the sampling controller, phase accumulator advanced per
// accepted strobe, mode-change tracking, and a shaper stage driving the DAC sample.
module dds_sample_engine
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned DATA_W  = 10
) (
  input  logic               Fg_CLK,
  input  logic               Fg_RESETn,
  input  logic               DDSEnable,
  input  logic               DDSReady,
  input  logic [2:0]         DDSMode,
  input  logic [1:0]         iWaveSel,
  input  logic [PHASE_W-1:0] iTuneWord,
  output logic [DATA_W-1:0]  oDacData,
  output logic               oDacValid,
  output logic               oBusy,
  output logic               oModeChg
);

  state_t             r_state;
  logic [PHASE_W-1:0] r_acc;
  logic [1:0]         r_sel;
  logic               r_s1_valid;
  logic [2:0]         r_prev_mode;
  logic               r_busy;
  logic               r_mode_chg;

  logic w_running;
  logic w_in_run;
  logic w_mode_chg;
  logic w_accept;
  logic w_flush;

  assign w_running  = mode_running(DDSMode);
  assign w_in_run   = (r_state == RUN) && DDSReady;
  assign w_mode_chg = w_in_run && w_running && (DDSMode != r_prev_mode);
  // A coincident mode change wins over the strobe.
  assign w_accept   = w_in_run && w_running && !w_mode_chg && DDSEnable;
  // Losing DDSReady or leaving RUN returns the DAC to midscale and drops in-flight work.
  assign w_flush    = !DDSReady || ((r_state == RUN) && !w_running);

  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) begin
      r_state     <= WAIT_READY;
      r_acc       <= '0;
      r_sel       <= WAVE_SAW;
      r_s1_valid  <= 1'b0;
      r_prev_mode <= 3'd0;
      r_busy      <= 1'b0;
      r_mode_chg  <= 1'b0;
    end else begin
      r_prev_mode <= DDSMode;
      r_mode_chg  <= w_mode_chg;
      r_s1_valid  <= w_accept;

      if (w_accept) begin
        r_acc <= r_acc + iTuneWord;
        r_sel <= iWaveSel;
      end else if (w_flush || w_mode_chg) begin
        r_acc <= '0;
      end

      if (!DDSReady) begin
        r_state <= WAIT_READY;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          WAIT_READY: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          IDLE: begin
            if (w_running) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
          RUN: begin
            if (!w_running) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= WAIT_READY;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  dds_wave_shaper #(
    .DATA_W (DATA_W)
  ) u_shaper (
    .Fg_CLK    (Fg_CLK),
    .Fg_RESETn (Fg_RESETn),
    .i_phase   (r_acc[PHASE_W-1 -: DATA_W]),
    .i_sel     (r_sel),
    .i_valid   (r_s1_valid),
    .i_flush   (w_flush),
    .o_data    (oDacData),
    .o_valid   (oDacValid)
  );

  assign oBusy    = r_busy;
  assign oModeChg = r_mode_chg;

endmodule

// File: tb/tb_dds_sample_engine.sv
// Directed bench for dds_sample_engine: a waveform vector table plus hand-written
// sequences for mode change, stop and DDSReady loss.
module tb_dds_sample_engine;

  logic        Fg_CLK = 1'b0;
  logic        Fg_RESETn;
  logic        DDSEnable;
  logic        DDSReady;
  logic [2:0]  DDSMode;
  logic [1:0]  iWaveSel;
  logic [15:0] iTuneWord;
  logic [9:0]  oDacData;
  logic        oDacValid;
  logic        oBusy;
  logic        oModeChg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic [1:0]  sel;
    logic [15:0] tune;
    logic [9:0]  exp_data;
  } vec_t;

  vec_t vecs[17];

  dds_sample_engine #(
    .PHASE_W (16),
    .DATA_W  (10)
  ) dut (
    .Fg_CLK    (Fg_CLK),
    .Fg_RESETn (Fg_RESETn),
    .DDSEnable (DDSEnable),
    .DDSReady  (DDSReady),
    .DDSMode   (DDSMode),
    .iWaveSel  (iWaveSel),
    .iTuneWord (iTuneWord),
    .oDacData  (oDacData),
    .oDacValid (oDacValid),
    .oBusy     (oBusy),
    .oModeChg  (oModeChg)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Strobe for one cycle, then scramble the sampled inputs to prove they are captured only
  // on the accepted strobe.
  task automatic strobe(input logic [1:0] sel, input logic [15:0] tune);
    @(negedge Fg_CLK);
    DDSEnable = 1'b1;
    iWaveSel  = sel;
    iTuneWord = tune;
    @(negedge Fg_CLK);
    DDSEnable = 1'b0;
    iWaveSel  = ~sel;
    iTuneWord = 16'hFFFF;
  endtask

  task automatic restart();
    @(negedge Fg_CLK);
    DDSMode = 3'd0;
    @(negedge Fg_CLK);
    DDSMode = 3'd1;
    repeat (3) @(negedge Fg_CLK);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 16'h0400, 10'd16};
    vecs[1]  = '{1'b0, 2'd0, 16'h0400, 10'd32};
    vecs[2]  = '{1'b0, 2'd0, 16'h0400, 10'd48};
    vecs[3]  = '{1'b0, 2'd0, 16'h0400, 10'd64};
    vecs[4]  = '{1'b1, 2'd0, 16'h4000, 10'd256};
    vecs[5]  = '{1'b0, 2'd0, 16'h4000, 10'd512};
    vecs[6]  = '{1'b0, 2'd0, 16'h4000, 10'd768};
    vecs[7]  = '{1'b0, 2'd0, 16'h4000, 10'd0};
    vecs[8]  = '{1'b0, 2'd0, 16'h4000, 10'd256};
    vecs[9]  = '{1'b1, 2'd1, 16'h4000, 10'd0};
    vecs[10] = '{1'b0, 2'd1, 16'h4000, 10'd1023};
    vecs[11] = '{1'b0, 2'd1, 16'h4000, 10'd1023};
    vecs[12] = '{1'b0, 2'd1, 16'h4000, 10'd0};
    vecs[13] = '{1'b1, 2'd2, 16'h4000, 10'd512};
    vecs[14] = '{1'b0, 2'd2, 16'h4000, 10'd1023};
    vecs[15] = '{1'b0, 2'd2, 16'h4000, 10'd511};
    vecs[16] = '{1'b0, 2'd2, 16'h4000, 10'd0};

    Fg_RESETn = 1'b0;
    DDSEnable = 1'b0;
    DDSReady  = 1'b0;
    DDSMode   = 3'd1;
    iWaveSel  = 2'd0;
    iTuneWord = 16'h0400;
    repeat (3) @(negedge Fg_CLK);
    Fg_RESETn = 1'b1;
    @(negedge Fg_CLK);
    check("rst_data", oDacData, 512);
    check("rst_valid", oDacValid, 0);
    check("rst_busy", oBusy, 0);
    check("rst_modechg", oModeChg, 0);

    // Strobes are ignored while the controller is not ready.
    for (int i = 0; i < 3; i++) begin
      strobe(2'd0, 16'h0400);
      @(negedge Fg_CLK);
      check("notready_valid", oDacValid, 0);
      check("notready_data", oDacData, 512);
      check("notready_busy", oBusy, 0);
      repeat (7) @(negedge Fg_CLK);
    end

    DDSReady = 1'b1;
    repeat (3) @(negedge Fg_CLK);
    check("run_busy", oBusy, 1);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].clr) restart();
      strobe(vecs[i].sel, vecs[i].tune);
      check("vec_valid_early", oDacValid, 0);
      @(negedge Fg_CLK);
      check("vec_valid", oDacValid, 1);
      check("vec_data", oDacData, vecs[i].exp_data);
      @(negedge Fg_CLK);
      check("vec_valid_pulse", oDacValid, 0);
      repeat (6) @(negedge Fg_CLK);
    end

    // Mode change 1->2 coincident with a strobe: strobe dropped, acc cleared.
    @(negedge Fg_CLK);
    DDSMode   = 3'd2;
    DDSEnable = 1'b1;
    iWaveSel  = 2'd0;
    iTuneWord = 16'h0400;
    @(negedge Fg_CLK);
    DDSEnable = 1'b0;
    check("modechg_pulse", oModeChg, 1);
    @(negedge Fg_CLK);
    check("modechg_one_cycle", oModeChg, 0);
    check("modechg_no_valid", oDacValid, 0);
    strobe(2'd0, 16'h0400);
    @(negedge Fg_CLK);
    check("modechg_next_valid", oDacValid, 1);
    check("modechg_next_data", oDacData, 16);
    check("modechg_busy", oBusy, 1);

    // Stop while running.
    @(negedge Fg_CLK);
    DDSMode = 3'd0;
    @(negedge Fg_CLK);
    check("stop_busy", oBusy, 0);
    check("stop_data", oDacData, 512);
    strobe(2'd0, 16'h0400);
    @(negedge Fg_CLK);
    check("stop_no_valid", oDacValid, 0);
    DDSMode = 3'd1;
    repeat (3) @(negedge Fg_CLK);
    check("restart_busy", oBusy, 1);
    strobe(2'd0, 16'h0400);
    @(negedge Fg_CLK);
    check("restart_valid", oDacValid, 1);
    check("restart_data", oDacData, 16);

    // DDSReady drops the cycle after a strobe: the in-flight sample is flushed.
    repeat (4) @(negedge Fg_CLK);
    DDSEnable = 1'b1;
    iWaveSel  = 2'd0;
    iTuneWord = 16'h0400;
    @(negedge Fg_CLK);
    DDSEnable = 1'b0;
    DDSReady  = 1'b0;
    @(negedge Fg_CLK);
    check("drop_valid", oDacValid, 0);
    check("drop_data", oDacData, 512);
    check("drop_busy", oBusy, 0);
    @(negedge Fg_CLK);
    check("drop_valid_late", oDacValid, 0);
    DDSReady = 1'b1;
    @(negedge Fg_CLK);
    check("ready_idle_busy", oBusy, 0);
    repeat (3) @(negedge Fg_CLK);
    check("ready_run_busy", oBusy, 1);
    strobe(2'd0, 16'h0400);
    @(negedge Fg_CLK);
    check("ready_valid", oDacValid, 1);
    check("ready_data", oDacData, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
